// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bridge state type, bus widths and default address map
package apb_pkg;
    localparam int APB_DW = 32;
    localparam int APB_AW = 32;
    localparam logic [APB_AW-1:0] APB_BASE_ADDR = 32'h1000_0000;
    localparam int APB_REGION_BITS = 12;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} apb_state_e;
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps an address region to a slave hit, index and one-hot select
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR = APB_BASE_ADDR,
    parameter int REGION_BITS = APB_REGION_BITS
) (
    input  logic [APB_AW-1:REGION_BITS] addr,
    output logic hit,
    output logic [2:0] index,
    output logic [NUM_SLAVES-1:0] sel
);
    localparam logic [APB_AW-1:REGION_BITS+3] BASE_TAG = BASE_ADDR[APB_AW-1:REGION_BITS+3];
    always_comb begin
        index = addr[REGION_BITS+2:REGION_BITS];
        hit = (addr[APB_AW-1:REGION_BITS+3] == BASE_TAG) && ({29'b0, index} < NUM_SLAVES);
        sel = hit ? NUM_SLAVES'(1) << index : '0;
    end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: core request/ready bus to APB3 master with decode and timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR = APB_BASE_ADDR,
    parameter int REGION_BITS = APB_REGION_BITS,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic transfer,
    input  logic dataWe,
    input  logic [APB_AW-1:0] dataAddr,
    input  logic [APB_DW-1:0] dataWData,
    output logic [APB_DW-1:0] dataRData,
    output logic ready,
    output logic err,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    output logic PWRITE,
    output logic PENABLE,
    output logic [NUM_SLAVES-1:0] PSEL,
    input  logic [NUM_SLAVES*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0] PREADY
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    apb_state_e state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] idx, index;
    logic hit, sel_ready;
    logic [NUM_SLAVES-1:0] sel;
    logic [APB_DW-1:0] rdata_sel;

    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR(BASE_ADDR),
        .REGION_BITS(REGION_BITS)
    ) u_dec (
        .addr(dataAddr[APB_AW-1:REGION_BITS]),
        .hit(hit),
        .index(index),
        .sel(sel)
    );

    always_comb begin
        sel_ready = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (idx == 3'(i)) begin
                sel_ready = PREADY[i];
                rdata_sel = PRDATA[APB_DW*i +: APB_DW];
            end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // a PREADY in the final timeout cycle still completes the transfer cleanly
    always_comb begin
        state_n = state;
        ready = 1'b0;
        err = 1'b0;
        dataRData = '0;
        case (state)
            IDLE: state_n = transfer ? (hit ? SETUP : ERROR) : IDLE;
            SETUP: state_n = ACCESS;
            ACCESS: begin
                ready = sel_ready || (cnt == LAST);
                err = !sel_ready && (cnt == LAST);
                dataRData = (sel_ready && !PWRITE) ? rdata_sel : '0;
                state_n = ready ? IDLE : ACCESS;
            end
            default: begin
                ready = 1'b1;
                err = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            PADDR <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            PENABLE <= 1'b0;
            PSEL <= '0;
            idx <= '0;
            cnt <= '0;
        end else begin
            if (state == IDLE && transfer) begin
                PADDR <= dataAddr;
                PWDATA <= dataWData;
                PWRITE <= dataWe;
                PSEL <= sel;
                idx <= index;
            end else if (state_n == IDLE) PSEL <= '0;
            PENABLE <= state_n == ACCESS;
            cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
        end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for the APB master bridge with wait-state slave model
module tb_apb_master_bridge;
    import apb_pkg::*;
    localparam int NS = 4;
    typedef struct packed {logic err; logic [31:0] data;} exp_t;

    logic clk = 0, reset = 1, transfer = 0, dataWe = 0;
    logic [31:0] dataAddr = 0, dataWData = 0;
    logic [31:0] dataRData, PADDR, PWDATA;
    logic ready, err, PWRITE, PENABLE;
    logic [NS-1:0] PSEL, PREADY;
    logic [NS*32-1:0] PRDATA;

    int slv_wait[NS];
    logic [31:0] slv_data[NS];
    int acc_cnt = 0;
    int total = 0, bad = 0, rc;
    exp_t exp_q[$];
    logic [3:0] psel_log[64];
    logic pen_log[64], rdy_log[64], pwrite_log[64];
    logic [31:0] paddr_log[64], pwdata_log[64];

    apb_master_bridge dut (
        .clk(clk), .reset(reset), .transfer(transfer), .dataWe(dataWe),
        .dataAddr(dataAddr), .dataWData(dataWData), .dataRData(dataRData),
        .ready(ready), .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 clk = ~clk;

    // slave i raises PREADY once it has seen slv_wait[i] ACCESS cycles
    always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
    always_comb begin
        PREADY = '0;
        PRDATA = '0;
        for (int i = 0; i < NS; i++) begin
            PREADY[i] = acc_cnt >= slv_wait[i];
            PRDATA[32*i +: 32] = slv_data[i];
        end
    end

    task automatic do_req(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_data, input int exp_cyc);
        exp_t e, g;
        bit got = 0;
        e.err = exp_err;
        e.data = exp_data;
        exp_q.push_back(e);
        transfer = 1; dataWe = we; dataAddr = addr; dataWData = wdata; rc = -1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            psel_log[c] = PSEL; pen_log[c] = PENABLE; rdy_log[c] = ready;
            pwrite_log[c] = PWRITE; paddr_log[c] = PADDR; pwdata_log[c] = PWDATA;
            if (got && c == rc + 1) begin
                total++;
                if (ready !== 1'b0) begin bad++; $display("FAIL %s ready_once: ready=%b required 0", name, ready); end
                break;
            end
            if (ready === 1'b1) begin
                got = 1; rc = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL %s unexpected_ready: queue empty", name); end
                else begin
                    g = exp_q.pop_front();
                    if (err !== g.err) begin bad++; $display("FAIL %s err: got %b required %b", name, err, g.err); end
                    total++;
                    if (dataRData !== g.data) begin bad++; $display("FAIL %s rdata: got %h required %h", name, dataRData, g.data); end
                    total++;
                    if (c != exp_cyc) begin bad++; $display("FAIL %s latency: got cycle %0d required %0d", name, c, exp_cyc); end
                end
            end
            @(posedge clk); #1;
            if (got) transfer = 0;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s no_ready: got none required cycle %0d", name, exp_cyc);
            transfer = 0;
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (PSEL !== 4'b0) begin bad++; $display("FAIL reset_psel: got %b required 0", PSEL); end
        total++; if (PENABLE !== 1'b0) begin bad++; $display("FAIL reset_penable: got %b required 0", PENABLE); end
        total++; if (ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_ready_err: got %b%b required 00", ready, err); end
        total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin
            bad++; $display("FAIL reset_regs: got %h %h %b required 0 0 0", PADDR, PWDATA, PWRITE); end
        total++; if (dataRData !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", dataRData); end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        do_req("write", 1, 32'h1000_1004, 32'hCAFE_F00D, 0, 32'h0, 2);
        total++; if (psel_log[1] !== 4'b0010) begin bad++; $display("FAIL write_psel_c1: got %b required 0010", psel_log[1]); end
        total++; if (pen_log[1] !== 1'b0) begin bad++; $display("FAIL write_penable_c1: got %b required 0", pen_log[1]); end
        total++; if (paddr_log[1] !== 32'h1000_1004) begin bad++; $display("FAIL write_paddr: got %h required 10001004", paddr_log[1]); end
        total++; if (pwdata_log[1] !== 32'hCAFE_F00D) begin bad++; $display("FAIL write_pwdata: got %h required cafef00d", pwdata_log[1]); end
        total++; if (pwrite_log[1] !== 1'b1) begin bad++; $display("FAIL write_pwrite: got %b required 1", pwrite_log[1]); end
        total++; if (pen_log[2] !== 1'b1) begin bad++; $display("FAIL write_penable_c2: got %b required 1", pen_log[2]); end
        total++; if (psel_log[3] !== 4'b0) begin bad++; $display("FAIL write_psel_c3: got %b required 0", psel_log[3]); end
    endtask

    task automatic test_read_wait;
        slv_wait[3] = 3; slv_data[3] = 32'h1234_5678;
        do_req("read_wait", 0, 32'h1000_3008, 32'h0, 0, 32'h1234_5678, 5);
        total++; if (pwrite_log[2] !== 1'b0) begin bad++; $display("FAIL read_pwrite: got %b required 0", pwrite_log[2]); end
        slv_wait[3] = 0;
    endtask

    task automatic test_unmapped;
        logic [31:0] addrs [2] = '{32'h2000_0000, 32'h1000_4000};
        for (int k = 0; k < 2; k++) begin
            logic any = 0;
            do_req("unmapped", 0, addrs[k], 32'h0, 1, 32'h0, 1);
            for (int c = 0; c <= rc + 1; c++) any |= |psel_log[c];
            total++; if (any !== 1'b0) begin bad++; $display("FAIL unmapped_psel %h: got asserted required never", addrs[k]); end
        end
    endtask

    task automatic test_timeout;
        slv_wait[0] = 1000; slv_wait[2] = 0;
        do_req("timeout", 0, 32'h1000_0000, 32'h0, 1, 32'h0, 17);
        total++; if (pen_log[18] !== 1'b0 || psel_log[18] !== 4'b0) begin
            bad++; $display("FAIL timeout_release: got penable=%b psel=%b required 0 0", pen_log[18], psel_log[18]); end
        slv_wait[0] = 15; slv_data[0] = 32'hA5A5_5A5A;
        do_req("timeout_win", 0, 32'h1000_0000, 32'h0, 0, 32'hA5A5_5A5A, 17);
        slv_wait[0] = 0;
    endtask

    task automatic test_reset_mid;
        slv_wait[0] = 1000;
        transfer = 1; dataWe = 0; dataAddr = 32'h1000_0000;
        repeat (4) @(negedge clk);
        total++; if (PENABLE !== 1'b1) begin bad++; $display("FAIL rstmid_pre_penable: got %b required 1", PENABLE); end
        #2 reset = 1;
        #1;
        total++; if (PSEL !== 4'b0 || PENABLE !== 1'b0) begin
            bad++; $display("FAIL rstmid_apb: got psel=%b penable=%b required 0 0", PSEL, PENABLE); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b required 0", ready); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d required IDLE", dut.state); end
        transfer = 0; slv_wait[0] = 0;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        do_req("after_reset", 1, 32'h1000_2000, 32'h5555_AAAA, 0, 32'h0, 2);
    endtask

    task automatic test_back_to_back;
        exp_t e, g;
        int n = 0, c1 = -1, c2 = -1;
        slv_data[1] = 32'h0BAD_BEEF;
        e.err = 0; e.data = 32'h0; exp_q.push_back(e);
        e.err = 0; e.data = 32'h0BAD_BEEF; exp_q.push_back(e);
        transfer = 1; dataWe = 1; dataAddr = 32'h1000_0000; dataWData = 32'h1111_2222;
        for (int c = 0; c < 12; c++) begin
            logic r;
            @(negedge clk);
            r = ready;
            if (c == 4) begin
                total++; if (PSEL !== 4'b0010) begin bad++; $display("FAIL b2b_psel: got %b required 0010", PSEL); end
            end
            if (r === 1'b1) begin
                n++;
                if (n == 1) c1 = c; else c2 = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_unexpected_ready: cycle %0d", c); end
                else begin
                    g = exp_q.pop_front();
                    if (err !== g.err || dataRData !== g.data) begin
                        bad++; $display("FAIL b2b_resp: got %b %h required %b %h", err, dataRData, g.err, g.data); end
                end
            end
            @(posedge clk); #1;
            if (r === 1'b1 && n == 1) begin dataWe = 0; dataAddr = 32'h1000_1000; end
            if (r === 1'b1 && n >= 2) transfer = 0;
        end
        transfer = 0;
        exp_q.delete();
        total++; if (n != 2) begin bad++; $display("FAIL b2b_count: got %0d readies required 2", n); end
        total++; if (c1 != 2 || c2 != 5) begin bad++; $display("FAIL b2b_cycles: got %0d,%0d required 2,5", c1, c2); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin slv_wait[i] = 0; slv_data[i] = 32'hD000_0000 + i; end
        test_reset;
        test_write;
        test_read_wait;
        test_unmapped;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within bound");
        $fatal(1);
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Bridges the RV32I core's data-side request/ready bus (transfer, dataWe, dataAddr, dataWData, dataRData, ready) onto a shared AMBA APB3 bus.
- Decodes the address to one of NUM_SLAVES peripheral regions and sequences the APB SETUP/ACCESS phases.
- Returns the read data and a one-cycle ready pulse to the core.
- Guards against a hung slave with a timeout and flags unmapped addresses.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (PSEL width); legal range 1..8.
- BASE_ADDR, 32'h1000_0000, start of the peripheral window.
- REGION_BITS, 12, log2 of bytes per slave region; default gives 4 KiB per slave, so slave i is at BASE_ADDR + i*4 KiB.
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before the transfer is aborted; legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- transfer  input  1  core request strobe; held high until ready.
- dataWe  input  1  1 = write, 0 = read; valid with transfer.
- dataAddr  input  32  byte address; valid with transfer.
- dataWData  input  32  write data; valid with transfer.
- dataRData  output  32  read data; valid only when ready=1.
- ready  output  1  one-cycle completion pulse to the core.
- err  output  1  qualifies ready: unmapped address or timeout.
- PADDR  output  32  APB address (registered copy of dataAddr).
- PWDATA  output  32  APB write data.
- PWRITE  output  1  APB direction.
- PENABLE  output  1  APB access phase.
- PSEL  output  NUM_SLAVES  one-hot slave select.
- PRDATA  input  NUM_SLAVES*32  concatenated slave read data; slave i occupies [32*i+31:32*i].
- PREADY  input  NUM_SLAVES  per-slave ready.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - PADDR, PWDATA, dataRData = 0.
  - PWRITE, PENABLE, PSEL, ready, err = 0.
  - Timeout counter = 0.
  - Takes effect immediately mid-transfer. No completion pulse is generated for an aborted request; the core re-issues after reset.
- FSM states: IDLE, SETUP, ACCESS, ERROR.
- IDLE:
  - On transfer=1, latch dataAddr, dataWData and dataWe into PADDR, PWDATA and PWRITE.
  - Decode the address. If it is mapped, go to SETUP and set PSEL to the one-hot index. If it is unmapped, go to ERROR with PSEL=0.
- Address decode:
  - Mapped iff dataAddr[31:REGION_BITS+3] == BASE_ADDR[31:REGION_BITS+3] and index = dataAddr[REGION_BITS+2:REGION_BITS] < NUM_SLAVES.
  - Decode is combinational on dataAddr, registered into PSEL.
- SETUP: PSEL held, PENABLE=0. Always advances to ACCESS on the next clock; counter cleared.
- ACCESS:
  - PENABLE=1, PSEL and PADDR stable.
  - When PREADY[index]=1: ready=1 and err=0 combinationally in the same cycle, and dataRData = PRDATA slice of index for reads, 0 for writes. Next state IDLE; PSEL and PENABLE go to 0.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 and PREADY is still 0: ready=1, err=1, dataRData=0, next state IDLE.
  - A PREADY arriving in the timeout cycle wins (err=0).
- ERROR: lasts one cycle. ready=1, err=1, dataRData=0, no APB activity; next state IDLE.
- Latency:
  - Best case: transfer sampled at cycle 0, SETUP at cycle 1, ACCESS with ready at cycle 2, giving a 3-cycle request-to-ready.
  - Unmapped address: 2 cycles.
  - Timeout: 2+TIMEOUT_CYCLES.
- Back-to-back: if transfer is still high in the IDLE cycle after ready, it is treated as a new request. The core must drop or update transfer on the ready cycle.
- Changes to the core inputs outside IDLE are ignored because the request is latched.
- PREADY from non-selected slaves is ignored.
- ready, err and dataRData are combinational from state, counter, PREADY and PRDATA; all other outputs are registered.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS, ERROR}.
  - Default address-map constants (BASE_ADDR, REGION_BITS).
  - APB_DW=32 and APB_AW=32.
- Sub-module apb_addr_decoder: purely combinational. Inputs: address. Outputs: hit, index and one-hot select. Parameterised by NUM_SLAVES, BASE_ADDR and REGION_BITS; reused by the system address map.

Test Plan:
- Write: transfer=1, dataWe=1, dataAddr=0x1000_1004, dataWData=0xCAFE_F00D, PREADY[1] tied high.
  - Cycle 1: PSEL=4'b0010, PENABLE=0, PADDR=0x1000_1004, PWDATA=0xCAFE_F00D.
  - Cycle 2: PENABLE=1, ready=1, err=0.
  - Cycle 3: PSEL=0.
- Read with wait states: read 0x1000_3008; PREADY[3] low for 3 ACCESS cycles, then high with PRDATA slice 3 = 0x1234_5678.
  - ready asserts exactly once, at cycle 5, with dataRData=0x1234_5678 and err=0.
- Unmapped address: read 0x2000_0000, then 0x1000_4000 (index 4 ≥ NUM_SLAVES).
  - Each gives PSEL never asserted, ready=1 and err=1 at cycle 1, dataRData=0.
- Timeout: read 0x1000_0000 with PREADY[0] held low.
  - ready=1 and err=1 at cycle 17 (2+16-1); PENABLE=0 and PSEL=0 at cycle 18.
  - Variant: PREADY[0] rises in cycle 17 → err=0, data returned.
- Reset mid-ACCESS: assert reset asynchronously between edges while PENABLE=1.
  - PSEL, PENABLE and ready drop immediately, without a clock edge; state=IDLE.
  - After release, a new write to 0x1000_2000 completes normally in 3 cycles.
- Back-to-back and isolation: two transfers (write 0x1000_0000, then read 0x1000_1000) with transfer held high across the first ready.
  - Second transfer's PSEL=4'b0010 in the cycle after the next IDLE.
  - PREADY from slave 2 asserted throughout never causes ready.
